// File: rtl/delay_sample_prog.sv
// -----------------------------------------------------------------------------
// delay_sample_prog
//
// Runtime-programmable sample delay line for the OFDM RX datapath. Every
// strobed input sample is written into a dual-port RAM (port A). The output
// sample is read on port B at an address that trails the write pointer by the
// active delay. A fill counter tracks how many samples have been accepted
// since the last reset or delay change. Outputs are only emitted once the line
// holds at least delay_act samples, so a delay change never emits stale data.
//
// Ports
//   clock          in   1           system clock
//   reset          in   1           synchronous, active-high
//   enable         in   1           block enable; low freezes all state
//   delay_cfg      in   ADDR_WIDTH  requested delay in samples (0 acts as 1)
//   data_in        in   DATA_WIDTH  input sample
//   input_strobe   in   1           data_in valid this cycle
//   data_out       out  DATA_WIDTH  sample from delay_act strobes earlier
//   output_strobe  out  1           data_out valid, single-cycle pulse
//   primed         out  1           line holds >= delay_act samples
//   delay_act      out  ADDR_WIDTH  delay currently in effect
// -----------------------------------------------------------------------------
module delay_sample_prog #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [ADDR_WIDTH-1:0] delay_cfg,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  input_strobe,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  output_strobe,
    output logic                  primed,
    output logic [ADDR_WIDTH-1:0] delay_act
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic [ADDR_WIDTH-1:0] fill_q,      fill_d;
    logic [ADDR_WIDTH-1:0] delay_act_q, delay_act_d;
    logic                  out_stb_q,   out_stb_d;
    logic [DATA_WIDTH-1:0] data_out_q;

    logic [ADDR_WIDTH-1:0] d_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  delay_change;
    logic                  wr_en;
    logic                  counted;
    logic                  rd_en;
    logic                  primed_w;

    // NOTE: combinational logic uses blocking assignments with every output
    // given a default first, so no latch can be inferred.
    always_comb begin
        d_req        = (delay_cfg == '0) ? ONE : delay_cfg;
        delay_change = enable && (d_req != delay_act_q);
        wr_en        = enable && input_strobe;
        // A strobe coinciding with a delay change is stored but not counted.
        counted      = wr_en && !delay_change;
        // delay_act is never 0, so rd_addr never equals wr_addr.
        rd_addr      = wr_addr_q - delay_act_q;
        primed_w     = (fill_q >= delay_act_q);
        rd_en        = counted && primed_w;

        wr_addr_d    = wr_addr_q;
        fill_d       = fill_q;
        delay_act_d  = delay_act_q;
        out_stb_d    = rd_en;

        if (wr_en) begin
            wr_addr_d = wr_addr_q + ONE;
        end

        if (delay_change) begin
            delay_act_d = d_req;
            fill_d      = '0;
        end else if (counted && (fill_q != '1)) begin
            fill_d = fill_q + ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr_q   <= '0;
            fill_q      <= '0;
            delay_act_q <= d_req;
            out_stb_q   <= 1'b0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            fill_q      <= fill_d;
            delay_act_q <= delay_act_d;
            out_stb_q   <= out_stb_d;
        end
    end

    // NOTE: the sample RAM has no reset so it maps onto block RAM; stale
    // contents are unreachable because fill restarts at 0.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            mem[wr_addr_q] <= data_in;
        end
    end

    // Registered read port; holds its value between output strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out_q <= '0;
        end else if (rd_en) begin
            data_out_q <= mem[rd_addr];
        end
    end

    assign data_out      = data_out_q;
    assign output_strobe = out_stb_q;
    assign primed        = primed_w;
    assign delay_act     = delay_act_q;

endmodule

// File: tb/tb_delay_sample_prog.sv
module tb_delay_sample_prog;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clock;
    logic          reset;
    logic          enable;
    logic [AW-1:0] delay_cfg;
    logic [DW-1:0] data_in;
    logic          input_strobe;
    logic [DW-1:0] data_out;
    logic          output_strobe;
    logic          primed;
    logic [AW-1:0] delay_act;

    int checks = 0;
    int errors = 0;

    delay_sample_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .delay_cfg    (delay_cfg),
        .data_in      (data_in),
        .input_strobe (input_strobe),
        .data_out     (data_out),
        .output_strobe(output_strobe),
        .primed       (primed),
        .delay_act    (delay_act)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: history of every written sample, delay and count of
    // accepted samples since the last reset / delay change.
    logic [DW-1:0] hist[$];
    int            m_delay;
    int            m_fill;
    logic [DW-1:0] m_dout;
    logic          m_ostb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic en, input int cfg,
                              input logic [DW-1:0] din, input logic stb);
        int dreq;
        dreq = (cfg == 0) ? 1 : cfg;
        if (rst) begin
            m_delay = dreq; m_fill = 0; m_dout = '0; m_ostb = 1'b0;
        end else if (!en) begin
            m_ostb = 1'b0;
        end else if (dreq != m_delay) begin
            m_delay = dreq; m_fill = 0; m_ostb = 1'b0;
            if (stb) hist.push_back(din);
        end else if (stb) begin
            if (m_fill >= m_delay) begin
                m_dout = hist[hist.size() - m_delay];
                m_ostb = 1'b1;
            end else begin
                m_ostb = 1'b0;
            end
            hist.push_back(din);
            if (m_fill < DEPTH - 1) m_fill++;
        end else begin
            m_ostb = 1'b0;
        end
        while (hist.size() > 2 * DEPTH) void'(hist.pop_front());
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic drive(input logic rst, input logic en, input int cfg,
                         input logic [DW-1:0] din, input logic stb);
        reset        = rst;
        enable       = en;
        delay_cfg    = AW'(cfg);
        data_in      = din;
        input_strobe = stb;
        model_step(rst, en, cfg, din, stb);
        @(posedge clock);
        #1;
        check("model_ostb",   64'(output_strobe), 64'(m_ostb));
        check("model_dout",   64'(data_out),      64'(m_dout));
        check("model_primed", 64'(primed),        64'(m_fill >= m_delay));
        check("model_dact",   64'(delay_act),     64'(m_delay));
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        int            cfg;
        logic [DW-1:0] din;
        logic          stb;
        logic          e_ostb;
        logic [DW-1:0] e_dout;
        logic          e_primed;
        int            e_dact;
    } vec_t;

    vec_t vecs[16];

    initial begin
        // Sparse strobes at delay 3, clamp of 0 to 1, enable freeze, reset.
        vecs[0]  = '{1'b1, 1'b1, 3,   0, 1'b0, 1'b0,   0, 1'b0, 3};
        vecs[1]  = '{1'b0, 1'b1, 3,  10, 1'b1, 1'b0,   0, 1'b0, 3};
        vecs[2]  = '{1'b0, 1'b1, 3,   0, 1'b0, 1'b0,   0, 1'b0, 3};
        vecs[3]  = '{1'b0, 1'b1, 3,  20, 1'b1, 1'b0,   0, 1'b0, 3};
        vecs[4]  = '{1'b0, 1'b1, 3,  30, 1'b1, 1'b0,   0, 1'b1, 3};
        vecs[5]  = '{1'b0, 1'b1, 3,   0, 1'b0, 1'b0,   0, 1'b1, 3};
        vecs[6]  = '{1'b0, 1'b1, 3,  40, 1'b1, 1'b1,  10, 1'b1, 3};
        vecs[7]  = '{1'b0, 1'b1, 3,   0, 1'b0, 1'b0,  10, 1'b1, 3};
        vecs[8]  = '{1'b0, 1'b1, 3,  50, 1'b1, 1'b1,  20, 1'b1, 3};
        vecs[9]  = '{1'b0, 1'b1, 0,   0, 1'b0, 1'b0,  20, 1'b0, 1};
        vecs[10] = '{1'b0, 1'b1, 0,  60, 1'b1, 1'b0,  20, 1'b1, 1};
        vecs[11] = '{1'b0, 1'b1, 0,  70, 1'b1, 1'b1,  60, 1'b1, 1};
        vecs[12] = '{1'b0, 1'b0, 0,  80, 1'b1, 1'b0,  60, 1'b1, 1};
        vecs[13] = '{1'b0, 1'b0, 5,  90, 1'b1, 1'b0,  60, 1'b1, 1};
        vecs[14] = '{1'b0, 1'b1, 0, 100, 1'b1, 1'b1,  70, 1'b1, 1};
        vecs[15] = '{1'b1, 1'b1, 0,   0, 1'b0, 1'b0,   0, 1'b0, 1};

        reset = 1'b1; enable = 1'b1; delay_cfg = '0; data_in = '0; input_strobe = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].cfg, vecs[i].din, vecs[i].stb);
            check($sformatf("vec%0d_ostb", i),   64'(output_strobe), 64'(vecs[i].e_ostb));
            check($sformatf("vec%0d_dout", i),   64'(data_out),      64'(vecs[i].e_dout));
            check($sformatf("vec%0d_primed", i), 64'(primed),        64'(vecs[i].e_primed));
            check($sformatf("vec%0d_dact", i),   64'(delay_act),     64'(vecs[i].e_dact));
        end

        // Fixed delay 5, strobe every cycle, counter data.
        drive(1'b1, 1'b1, 5, 0, 1'b0);
        for (int n = 0; n < 12; n++) begin
            drive(1'b0, 1'b1, 5, DW'(n), 1'b1);
            check("fix_primed", 64'(primed), 64'(n >= 4));
            check("fix_ostb", 64'(output_strobe), 64'(n >= 5));
            if (n >= 5) check("fix_dout", 64'(data_out), 64'(n - 5));
        end

        // Max delay 63 across the address wrap.
        drive(1'b1, 1'b1, 63, 0, 1'b0);
        for (int n = 0; n < 200; n++) begin
            drive(1'b0, 1'b1, 63, DW'(n), 1'b1);
            check("max_ostb", 64'(output_strobe), 64'(n >= 63));
            if (n >= 63) check("max_dout", 64'(data_out), 64'(n - 63));
        end

        // Delay change 4 -> 7 mid-stream.
        drive(1'b1, 1'b1, 4, 0, 1'b0);
        for (int n = 0; n < 20; n++) drive(1'b0, 1'b1, 4, DW'(100 + n), 1'b1);
        check("chg_pre_dout", 64'(data_out), 64'(115));
        drive(1'b0, 1'b1, 7, 500, 1'b1);
        check("chg_ostb0", 64'(output_strobe), 64'(0));
        check("chg_primed0", 64'(primed), 64'(0));
        check("chg_dact", 64'(delay_act), 64'(7));
        for (int k = 1; k <= 7; k++) begin
            drive(1'b0, 1'b1, 7, DW'(500 + k), 1'b1);
            check("chg_ostb", 64'(output_strobe), 64'(0));
            check("chg_primed", 64'(primed), 64'(k == 7));
        end
        drive(1'b0, 1'b1, 7, 508, 1'b1);
        check("chg_first_ostb", 64'(output_strobe), 64'(1));
        check("chg_first_dout", 64'(data_out), 64'(501));

        // Enable low with strobes: nothing moves, then resumes seamlessly.
        for (int n = 0; n < 10; n++) begin
            drive(1'b0, 1'b0, 2, DW'(900 + n), 1'b1);
            check("frz_ostb", 64'(output_strobe), 64'(0));
            check("frz_dact", 64'(delay_act), 64'(7));
        end
        drive(1'b0, 1'b1, 7, 509, 1'b1);
        check("frz_resume_dout", 64'(data_out), 64'(502));

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic rst, en, stb;
            int   cfg;
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 9) != 0);
            stb = ($urandom_range(0, 9) < 7);
            cfg = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'(delay_cfg);
            drive(rst, en, cfg, DW'($urandom), stb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
